goldschmidt_iter: RTL and testbench
===================================

GOLDSCHMIDT_ITER -- requirements
Module: goldschmidt_iter

Interface
REQ-001 Parameter ITERS, default 3: number of Goldschmidt refinement iterations, legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 n  input  8  dividend, unsigned Q0.8; sampled with start.
REQ-006 d  input  8  divisor, unsigned Q0.8, normalized (d[7]=1); sampled with start.
REQ-007 rom_addr  output  3  registered seed-ROM address, driven from divisor bits [6:4].
REQ-008 rom_data  input  3  combinational seed-ROM reply; valid in the same cycle as rom_addr.
REQ-009 busy  output  1  high in LOOKUP, ITER and DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  set when the sampled divisor was not normalized; valid while done=1 and held until the next start.
REQ-012 q  output  16  quotient, unsigned Q2.14; held until the next accepted start.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, LOOKUP, ITER and DONE.
REQ-014 IDLE with start=1 SHALL load N={2'b00,n,6'b0} and D={2'b00,d,6'b0} (Q2.14), set rom_addr=d[6:4], set err=~d[7], and go to LOOKUP.
REQ-015 LOOKUP SHALL load F={2'b01,rom_data,11'b0} (value 1+rom_data/8), clear the iteration count and go to ITER; a non-normalized divisor SHALL go directly to DONE with q=16'hFFFF.
REQ-016 Each ITER cycle SHALL perform N<=trunc(N*F), D<=trunc(D*F) and F<=16'h8000-D_new, where trunc takes bits [29:14] of the 32-bit product.
REQ-017 All three updates SHALL occur in the same cycle.
REQ-018 After ITERS iterations the FSM SHALL register q=N and go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle following the (ITERS+2)th rising edge after the edge that sampled start.
REQ-021 start outside IDLE SHALL be ignored, with no effect on state or outputs.
REQ-022 A start sampled in the DONE cycle SHALL be ignored; back-to-back throughput is one operation per ITERS+3 cycles.
REQ-023 Products SHALL never be stored wider than 16 bits; overflow above bit 29 SHALL be discarded silently.
REQ-024 The iteration counter SHALL be 3 bits wide and SHALL NOT wrap within a legal ITERS value.

Reset
REQ-025 On rst=1 the block SHALL enter IDLE and clear busy, done, err, q, rom_addr, N, D, F and the counter.
REQ-026 rst SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.

Configuration
REQ-027 Macro GS_ROUND_EN defined: trunc in REQ-016 SHALL be replaced by round-half-up, i.e. bits [29:14] of (product + 32'h2000), for both N and D.
REQ-028 Macro GS_ROUND_EN undefined: pure truncation as in REQ-016.

Verification
REQ-029 n=8'h80, d=8'h80, stub rom_data=3'b111, ITERS=3, no macro -> rom_addr=0, done 5 edges after start, q=16'h3FFF, err=0.
REQ-030 The REQ-029 stimulus with GS_ROUND_EN defined -> q=16'h4000.
REQ-031 d=8'h40 (not normalized), n=8'h20 -> done 2 edges after start, q=16'hFFFF, err=1.
REQ-032 Repeated start pulses while busy=1 -> ignored; q and the done timing match a single operation.
REQ-033 rst asserted in the second ITER cycle -> next cycle busy=0, q=0, no done pulse; a new start then completes normally.
REQ-034 Back-to-back starts, with start held high continuously -> done pulses exactly ITERS+3 cycles apart, each with the correct q.

Source files
------------

// File: rtl/goldschmidt_iter.sv
// goldschmidt_iter: multi-cycle Goldschmidt divider, q = n/d in Q2.14.
// The divisor is normalized (d[7]=1). A small external seed ROM, addressed
// by d[6:4], supplies the first factor F = 1 + rom_data/8.
// Optional macro GS_ROUND_EN: round-half-up on every N/D product instead of
// plain truncation.
module goldschmidt_iter #(
  parameter int ITERS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [7:0]  d,
  output logic [2:0]  rom_addr,
  input  logic [2:0]  rom_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] q
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ITER, DONE} state_t;

`ifdef GS_ROUND_EN
  localparam logic [31:0] RND = 32'h0000_2000;
`else
  localparam logic [31:0] RND = 32'h0000_0000;
`endif

  // The counter compares against ITERS-1, so 3 bits cover ITERS up to 7
  // without wrapping.
  localparam logic [2:0] LAST = 3'(ITERS - 1);

  state_t      r_state, w_next;
  logic [15:0] r_n, r_d, r_f, r_q;
  logic [2:0]  r_cnt, r_rom_addr;
  logic        r_err, r_done;
  logic [15:0] w_n_new, w_d_new;

  // Q2.14 x Q2.14 products keep bits [29:14]; anything above is dropped.
  assign w_n_new = 16'((32'(r_n) * 32'(r_f) + RND) >> 14);
  assign w_d_new = 16'((32'(r_d) * 32'(r_f) + RND) >> 14);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a bad divisor skips the iterations entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOOKUP;
      LOOKUP:  w_next = r_err ? DONE : ITER;
      ITER:    if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, seed load, and the N/D/F refinement step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= '0;
      r_d        <= '0;
      r_f        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // done is registered off DONE so it lands while the FSM is back in
      // IDLE; this keeps the repeat period at ITERS+3 with start held high.
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n        <= {2'b00, n, 6'b0};
            r_d        <= {2'b00, d, 6'b0};
            r_rom_addr <= d[6:4];
            r_err      <= ~d[7];
          end
        end
        LOOKUP: begin
          r_f   <= {2'b01, rom_data, 11'b0};
          r_cnt <= '0;
          if (r_err) r_q <= 16'hFFFF;
        end
        ITER: begin
          r_n   <= w_n_new;
          r_d   <= w_d_new;
          r_f   <= 16'h8000 - w_d_new;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAST) r_q <= w_n_new;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr = r_rom_addr;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign q        = r_q;

endmodule

// File: tb/tb_goldschmidt_iter.sv
// Self-checking bench for goldschmidt_iter: fixed vectors, hand sequences for
// busy-time starts, reset abort and back-to-back operation, and random ops
// against an arithmetic reference model.
module tb_goldschmidt_iter;
  localparam int ITERS = 3;

  logic        clk, rst, start;
  logic [7:0]  n, d;
  logic [2:0]  rom_addr, rom_data;
  logic        busy, done, err;
  logic [15:0] q;

  int checks = 0;
  int errors = 0;

  // Seed ROM stub: rough 1/d seeds, F = 1 + seed/8
  logic [2:0] rom_tbl [0:7] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
  assign rom_data = rom_tbl[rom_addr];

  goldschmidt_iter #(.ITERS(ITERS)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .d(d),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .err(err), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the Goldschmidt recurrence done with plain integer arithmetic
  function automatic void model(input logic [7:0] mn, input logic [7:0] md,
                                output logic [15:0] mq, output logic me, output int ml);
    longint nn, dd, ff, rnd;
`ifdef GS_ROUND_EN
    rnd = 8192;
`else
    rnd = 0;
`endif
    if (!md[7]) begin
      mq = 16'hFFFF; me = 1'b1; ml = 2;
    end else begin
      nn = longint'(mn) * 64;
      dd = longint'(md) * 64;
      ff = 16384 + longint'(rom_tbl[md[6:4]]) * 2048;
      for (int i = 0; i < ITERS; i++) begin
        nn = ((nn * ff + rnd) / 16384) % 65536;
        dd = ((dd * ff + rnd) / 16384) % 65536;
        ff = (32768 - dd + 65536) % 65536;
      end
      mq = 16'(nn); me = 1'b0; ml = ITERS + 2;
    end
  endfunction

  // One operation from IDLE. noise>0 keeps pulsing start with junk operands
  // for that many cycles after acceptance. lat counts edges after the
  // sampling edge up to the one after which done is seen (-1 on timeout).
  task automatic run_op(input logic [7:0] an, input logic [7:0] ad, input int noise,
                        output int lat, output logic [15:0] oq, output logic oerr,
                        output logic [2:0] oaddr);
    int k;
    @(negedge clk);
    n = an; d = ad; start = 1'b1;
    @(posedge clk);
    lat = -1; k = 0;
    while (k < 40) begin
      @(negedge clk);
      start = (k < noise);
      if (start) begin n = 8'($urandom); d = 8'($urandom); end
      @(posedge clk);
      k++;
      #1;
      if (done) begin lat = k; break; end
    end
    oq = q; oerr = err; oaddr = rom_addr;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  n, d;
    logic [15:0] q;
    logic        err;
    logic [2:0]  addr;
    int          lat;
  } vec_t;

  vec_t vt [4];

  initial begin
    int lat, ml;
    logic [15:0] aq, mq;
    logic ae, me;
    logic [2:0] aa;
    int dn_edge [$];
    logic [15:0] dn_q [$];

`ifdef GS_ROUND_EN
    vt[0] = '{8'h80, 8'h80, 16'h4000, 1'b0, 3'd0, ITERS + 2};
    vt[1] = '{8'hFF, 8'h80, 16'h7F80, 1'b0, 3'd0, ITERS + 2};
`else
    vt[0] = '{8'h80, 8'h80, 16'h3FFF, 1'b0, 3'd0, ITERS + 2};
    vt[1] = '{8'hFF, 8'h80, 16'h7F7F, 1'b0, 3'd0, ITERS + 2};
`endif
    vt[2] = '{8'h00, 8'h80, 16'h0000, 1'b0, 3'd0, ITERS + 2};
    vt[3] = '{8'h20, 8'h40, 16'hFFFF, 1'b1, 3'd4, 2};

    rst = 1'b1; start = 1'b0; n = '0; d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err",  {31'b0, err},  0);
    chk("rst_q",    {16'b0, q},    0);
    chk("rst_addr", {29'b0, rom_addr}, 0);
    @(negedge clk); rst = 1'b0;

    // Fixed vectors
    foreach (vt[i]) begin
      run_op(vt[i].n, vt[i].d, 0, lat, aq, ae, aa);
      chk("vec_q",    {16'b0, aq}, {16'b0, vt[i].q});
      chk("vec_err",  {31'b0, ae}, {31'b0, vt[i].err});
      chk("vec_addr", {29'b0, aa}, {29'b0, vt[i].addr});
      chk("vec_lat",  lat, vt[i].lat);
    end

    // Starts while busy are ignored
    run_op(8'h80, 8'h80, ITERS, lat, aq, ae, aa);
    chk("busy_start_q",   {16'b0, aq}, {16'b0, vt[0].q});
    chk("busy_start_lat", lat, ITERS + 2);

    // Reset in the second ITER cycle aborts with no done
    @(negedge clk); n = 8'hFF; d = 8'h80; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);           // LOOKUP -> ITER
    @(posedge clk);           // first iteration
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_q",    {16'b0, q},    0);
    chk("abort_done", {31'b0, done}, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      repeat (10) begin @(posedge clk); #1; if (done) seen++; end
      chk("abort_no_done", seen, 0);
    end
    run_op(8'h80, 8'h80, 0, lat, aq, ae, aa);
    chk("after_abort_q",   {16'b0, aq}, {16'b0, vt[0].q});
    chk("after_abort_lat", lat, ITERS + 2);

    // Back-to-back with start held high
    @(negedge clk); n = 8'hFF; d = 8'h80; start = 1'b1;
    for (int e = 0; e < 4 * (ITERS + 3); e++) begin
      @(posedge clk); #1;
      if (done) begin dn_edge.push_back(e); dn_q.push_back(q); end
    end
    @(negedge clk); start = 1'b0;
    repeat (2 * (ITERS + 3)) @(posedge clk);
    chk("b2b_count", dn_edge.size(), 4);
    if (dn_edge.size() > 0) chk("b2b_first", dn_edge[0], ITERS + 2);
    for (int i = 0; i < dn_edge.size(); i++) begin
      chk("b2b_q", {16'b0, dn_q[i]}, {16'b0, vt[1].q});
      if (i > 0) chk("b2b_gap", dn_edge[i] - dn_edge[i-1], ITERS + 3);
    end

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] rn, rd;
      rn = 8'($urandom);
      rd = 8'($urandom);
      if ($urandom_range(0, 7) != 0) rd[7] = 1'b1;
      model(rn, rd, mq, me, ml);
      run_op(rn, rd, 0, lat, aq, ae, aa);
      chk("rnd_q",    {16'b0, aq}, {16'b0, mq});
      chk("rnd_err",  {31'b0, ae}, {31'b0, me});
      chk("rnd_addr", {29'b0, aa}, {29'b0, rd[6:4]});
      chk("rnd_lat",  lat, ml);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
